// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_pkg
// Description : Shared types and constants for the I2C register target:
//               controller state encoding, input-conditioning widths and
//               byte framing constants.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

  // Depth of the metastability synchronizer in front of each glitch filter
  localparam int c_sync_stages = 2;

  // Default number of identical samples needed to accept a new bus level
  localparam int c_filt_len_default = 4;

  // Bit counter width; it must be able to hold the value 8 (a full byte)
  localparam int c_bit_cnt_w = 4;

  // Bit count at which a byte has been completely transferred
  localparam logic [c_bit_cnt_w-1:0] c_byte_bits = 4'd8;

  // Protocol controller states
  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RD_ACK    = 4'd8,
    ST_IGNORE    = 4'd9
  } i2c_state_t;

endpackage
`default_nettype wire

// File: rtl/i2c_glitch_filter.sv
`default_nettype none
// ============================================================================
// Module      : i2c_glitch_filter
// Description : Synchronizes one asynchronous bus line into iCLK and only
//               accepts a new level after LEN consecutive identical samples.
//               All stages power up / reset to 1 (idle bus level).
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_glitch_filter
  import i2c_pkg::*;
#(
  parameter int LEN = c_filt_len_default  // minimum 2
) (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic raw,
  output logic level
);

  logic [c_sync_stages-1:0] r_sync;
  logic [LEN-1:0]           r_hist;

  // Two-stage synchronizer, history shift register and level decision
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_sync <= '1;
      r_hist <= '1;
      level  <= 1'b1;
    end else begin
      r_sync <= {r_sync[c_sync_stages-2:0], raw};
      r_hist <= {r_hist[LEN-2:0], r_sync[c_sync_stages-1]};
      // Only a history that is unanimous moves the output; mixed history
      // (a glitch shorter than LEN samples) leaves the level untouched.
      if (&r_hist) begin
        level <= 1'b1;
      end else if (~|r_hist) begin
        level <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2c_target.sv
`default_nettype none
// ============================================================================
// Module      : i2c_target
// Description : I2C target (no clock stretching) exposing a 256x8 register
//               file. Bus protocol: [addr/W][ptr][data...] writes with an
//               auto-incrementing pointer, [addr/R][data...] reads from the
//               persistent pointer. A local port reads the same register file.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h39,
  parameter int         FILT_LEN = c_filt_len_default
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       I2C_SCL,
  inout  wire        I2C_SDA,
  output logic       wr_stb,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [7:0] host_addr,
  output logic [7:0] host_data,
  output logic       busy
);

  // Filtered bus levels and their previous-cycle copies
  logic w_scl;
  logic w_sda;
  logic r_scl_d;
  logic r_sda_d;

  // Bus events
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;

  // Controller state
  i2c_state_t r_state;
  i2c_state_t w_state_nxt;

  // Datapath registers
  logic [c_bit_cnt_w-1:0] r_bit_cnt;
  logic [7:0]             r_shift;   // receive shift register
  logic [6:0]             r_tx;      // read bits still to be sent, MSB next
  logic [7:0]             r_ptr;
  logic                   r_sda_oe;  // 1 = pull SDA low

  // Control strobes decoded from the state transition
  logic w_byte_full;
  logic w_addr_match;
  logic w_cnt_clr;
  logic w_cnt_inc;
  logic w_shift_in;
  logic w_tx_load;
  logic w_tx_shift;
  logic w_ptr_load;
  logic w_ptr_inc;
  logic w_wr_en;
  logic w_oe_nxt;

  // Register file and bus-side read port
  logic [7:0] r_mem [256];
  logic [7:0] w_rd_idx;
  logic [7:0] w_rd_byte;

  // --------------------------------------------------------------------------
  // Input conditioning
  // --------------------------------------------------------------------------
  i2c_glitch_filter #(.LEN(FILT_LEN)) u_scl_filt (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .raw    (I2C_SCL),
    .level  (w_scl)
  );

  i2c_glitch_filter #(.LEN(FILT_LEN)) u_sda_filt (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .raw    (I2C_SDA),
    .level  (w_sda)
  );

  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

  assign w_byte_full  = (r_bit_cnt == c_byte_bits);
  assign w_addr_match = (r_shift[7:1] == DEV_ADDR);

  // During the initiator's ACK slot the next byte is fetched one ahead
  assign w_rd_idx  = (r_state == ST_RD_ACK) ? r_ptr + 8'd1 : r_ptr;
  assign w_rd_byte = r_mem[w_rd_idx];

  // Open-drain output; reset gates the drive so SDA is released at once
  assign I2C_SDA = (r_sda_oe && iRST_N) ? 1'b0 : 1'bz;

  // --------------------------------------------------------------------------
  // Controller
  // --------------------------------------------------------------------------

  // State register
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: START/STOP override everything, else advance on SCL fall
  always_comb begin
    w_state_nxt = r_state;
    if (w_stop) begin
      w_state_nxt = ST_IDLE;
    end else if (w_start) begin
      w_state_nxt = ST_ADDR;
    end else if (w_scl_fall) begin
      case (r_state)
        ST_ADDR: begin
          if (w_byte_full) begin
            w_state_nxt = w_addr_match ? ST_ADDR_ACK : ST_IGNORE;
          end
        end
        // r_shift[0] still holds the R/W bit of the address byte
        ST_ADDR_ACK:  w_state_nxt = r_shift[0] ? ST_RDATA : ST_PTR;
        ST_PTR:       if (w_byte_full) w_state_nxt = ST_PTR_ACK;
        ST_PTR_ACK:   w_state_nxt = ST_WDATA;
        ST_WDATA:     if (w_byte_full) w_state_nxt = ST_WDATA_ACK;
        ST_WDATA_ACK: w_state_nxt = ST_WDATA;
        ST_RDATA:     if (w_byte_full) w_state_nxt = ST_RD_ACK;
        // r_shift[0] holds the bit the initiator put in its ACK slot
        ST_RD_ACK:    w_state_nxt = r_shift[0] ? ST_IGNORE : ST_RDATA;
        default:      w_state_nxt = r_state;
      endcase
    end
  end

  // Output decode: datapath strobes and the next SDA drive value
  always_comb begin
    w_cnt_clr  = w_start || (w_state_nxt != r_state);
    w_cnt_inc  = 1'b0;
    w_shift_in = 1'b0;
    case (r_state)
      ST_ADDR, ST_PTR, ST_WDATA: begin
        w_cnt_inc  = w_scl_rise && !w_byte_full;
        w_shift_in = w_scl_rise && !w_byte_full;
      end
      ST_RDATA:  w_cnt_inc  = w_scl_rise && !w_byte_full;
      ST_RD_ACK: w_shift_in = w_scl_rise;
      default: begin
        w_cnt_inc  = 1'b0;
        w_shift_in = 1'b0;
      end
    endcase

    w_ptr_load = (r_state == ST_PTR)   && (w_state_nxt == ST_PTR_ACK);
    w_wr_en    = (r_state == ST_WDATA) && (w_state_nxt == ST_WDATA_ACK);
    w_ptr_inc  = ((r_state == ST_WDATA_ACK) && (w_state_nxt == ST_WDATA)) ||
                 ((r_state == ST_RD_ACK)    && (w_state_nxt == ST_RDATA));
    w_tx_load  = (r_state != ST_RDATA) && (w_state_nxt == ST_RDATA);
    w_tx_shift = (r_state == ST_RDATA) && (w_state_nxt == ST_RDATA) && w_scl_fall;

    // SDA only changes on an SCL fall, except START/STOP which release it
    w_oe_nxt = r_sda_oe;
    if (w_start || w_stop) begin
      w_oe_nxt = 1'b0;
    end else if (w_scl_fall) begin
      case (w_state_nxt)
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: w_oe_nxt = 1'b1;
        ST_RDATA: w_oe_nxt = w_tx_load ? ~w_rd_byte[7] : ~r_tx[6];
        default:  w_oe_nxt = 1'b0;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------

  // Edge history, bit counting, shifting, pointer, SDA drive and write port
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_scl_d   <= 1'b1;
      r_sda_d   <= 1'b1;
      r_bit_cnt <= '0;
      r_shift   <= 8'h00;
      r_tx      <= 7'h00;
      r_ptr     <= 8'h00;
      r_sda_oe  <= 1'b0;
      wr_stb    <= 1'b0;
      wr_addr   <= 8'h00;
      wr_data   <= 8'h00;
      busy      <= 1'b0;
    end else begin
      r_scl_d  <= w_scl;
      r_sda_d  <= w_sda;
      r_sda_oe <= w_oe_nxt;

      if (w_cnt_clr) begin
        r_bit_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end

      if (w_shift_in) begin
        r_shift <= {r_shift[6:0], w_sda};
      end

      // MSB goes straight to the drive register; keep the remaining bits
      if (w_tx_load) begin
        r_tx <= w_rd_byte[6:0];
      end else if (w_tx_shift) begin
        r_tx <= {r_tx[5:0], 1'b0};
      end

      if (w_ptr_load) begin
        r_ptr <= r_shift;
      end else if (w_ptr_inc) begin
        r_ptr <= r_ptr + 8'd1;
      end

      wr_stb <= w_wr_en;
      if (w_wr_en) begin
        wr_addr <= r_ptr;
        wr_data <= r_shift;
      end

      if (w_start) begin
        busy <= 1'b1;
      end else if (w_stop) begin
        busy <= 1'b0;
      end
    end
  end

  // Register file write port; contents intentionally survive reset
  always_ff @(posedge iCLK) begin
    if (w_wr_en) begin
      r_mem[r_ptr] <= r_shift;
    end
  end

  // Registered host read port; a same-cycle bus write returns the old value
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      host_data <= 8'h00;
    end else begin
      host_data <= r_mem[host_addr];
    end
  end

endmodule
`default_nettype wire
